// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch/decode sequencer driving the pc block's control strobes.
module fetch_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic [4:0]  flags,
  output logic [15:0] ir,
  output logic [3:0]  rtgt_sel,
  input  logic [15:0] rtgt_data,
  output logic        ex_start,
  input  logic        ex_done,
  output logic        link_we,
  output logic [3:0]  link_sel,
  output logic        ra_buf,
  output logic        branch,
  output logic        jump,
  output logic        pcEn,
  output logic [7:0]  disp,
  output logic [15:0] dSrc,
  output logic        fault
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, LINK, UPDATE, FAULT} state_t;
  state_t st;
  logic [15:0] ir_q;
  logic [TW-1:0] tcnt;
  logic take, started, is_b, is_j, is_jal;
  // Odd condition codes are the complement of the even code below them.
  function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] f);
    logic [7:0] tbl;
    tbl = {1'b1, ~f[0] & ~f[1], ~f[3] & ~f[1], f[2], f[0], f[3], f[4], f[1]};
    return tbl[cc[3:1]] ^ cc[0];
  endfunction
  assign is_b   = ir_q[15:12] == 4'b1100;
  assign is_j   = ir_q[15:12] == 4'b0100 && ir_q[7:4] == 4'b1100;
  assign is_jal = ir_q[15:12] == 4'b0100 && ir_q[7:4] == 4'b1000;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= FETCH;
      ir_q    <= '0;
      take    <= 1'b0;
      tcnt    <= '0;
      started <= 1'b0;
    end else begin
      started <= st == EXEC;
      case (st)
        FETCH:
          if (imem_ack) begin
            ir_q <= imem_data;
            tcnt <= '0;
            st   <= DECODE;
          end else if (tcnt == TLAST) st <= FAULT;
          else tcnt <= tcnt + 1'b1;
        DECODE: begin
          take <= is_jal | cond_met(ir_q[11:8], flags);
          st   <= (is_b | is_j) ? UPDATE : is_jal ? LINK : EXEC;
        end
        EXEC:
          if (ex_done) begin
            take <= 1'b0;
            st   <= UPDATE;
          end
        LINK:    st <= UPDATE;
        UPDATE:  st <= FETCH;
        default: st <= FAULT;
      endcase
    end
  end
  // Outputs decode the current state and are all held at zero while reset is asserted.
  assign imem_req  = rst && st == FETCH;
  assign imem_addr = imem_req ? pc : '0;
  assign ir        = rst ? ir_q : '0;
  assign rtgt_sel  = ir[3:0];
  assign link_sel  = ir[11:8];
  assign disp      = ir[7:0];
  assign dSrc      = rst ? rtgt_data : '0;
  assign ex_start  = rst && st == EXEC && !started;
  assign link_we   = rst && st == LINK;
  assign ra_buf    = link_we;
  assign pcEn      = rst && st == UPDATE;
  assign branch    = pcEn && take && is_b;
  assign jump      = pcEn && take && (is_j || is_jal);
  assign fault     = rst && st == FAULT;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench checking fetch_ctrl against a cycle-schedule reference model.
module tb_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] pc = '0, imem_data = '0, rtgt_data = '0;
  logic imem_ack = 1'b0, ex_done = 1'b0;
  logic [4:0] flags = '0;
  logic imem_req, ex_start, link_we, ra_buf, branch, jump, pcEn, fault;
  logic [15:0] imem_addr, ir, dSrc;
  logic [3:0] rtgt_sel, link_sel;
  logic [7:0] disp;
  int vecs = 0, errs = 0;

  fetch_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .flags(flags), .ir(ir),
    .rtgt_sel(rtgt_sel), .rtgt_data(rtgt_data), .ex_start(ex_start), .ex_done(ex_done),
    .link_we(link_we), .link_sel(link_sel), .ra_buf(ra_buf), .branch(branch),
    .jump(jump), .pcEn(pcEn), .disp(disp), .dSrc(dSrc), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ref(input logic [3:0] cc, input logic [4:0] f);
    logic c, l, fl, z, n;
    {c, l, fl, z, n} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return fl;
      4'd9:  return !fl;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    logic [71:0] got;
    got = {imem_req, imem_addr, ir, rtgt_sel, ex_start, link_we, link_sel, ra_buf,
           branch, jump, pcEn, disp, dSrc, fault};
    vecs++;
    if (got !== '0) begin
      errs++;
      $display("FAIL %s outputs in reset: got %h expected 0", nm, got);
    end
  endtask

  // One instruction, entered at the start of a FETCH cycle; ad = ack cycle, ed = ex_done delay after ex_start.
  task automatic run_instr(input logic [15:0] instr, input int ad, input int ed,
                           input logic [4:0] fd, input logic [15:0] rd, input string nm);
    logic isb, isj, isjal, tk;
    logic [7:0] exp_s, got_s;
    logic [15:0] pcv;
    int d, l, s, u;
    isb   = instr[15:12] == 4'hC;
    isj   = instr[15:12] == 4'h4 && instr[7:4] == 4'hC;
    isjal = instr[15:12] == 4'h4 && instr[7:4] == 4'h8;
    tk    = isjal || ((isb || isj) && cond_ref(instr[11:8], fd));
    d = ad + 1;
    l = -1;
    s = -1;
    if (isb || isj) u = d + 1;
    else if (isjal) begin
      l = d + 1;
      u = d + 2;
    end else begin
      s = d + 1;
      u = s + ed + 1;
    end
    pcv = 16'($urandom);
    for (int c = 0; c <= u; c++) begin
      pc        = pcv;
      imem_ack  = c == ad;
      imem_data = (c == ad) ? instr : 16'($urandom);
      flags     = (c == d) ? fd : 5'($urandom);
      rtgt_data = rd;
      ex_done   = (s >= 0 && c == u - 1) ? 1'b1 : (c < s) ? 1'($urandom) : 1'b0;
      #1;
      exp_s = {c <= ad, c == s, c == l, c == l, c == u, c == u && tk && isb,
               c == u && tk && (isj || isjal), 1'b0};
      got_s = {imem_req, ex_start, link_we, ra_buf, pcEn, branch, jump, fault};
      vecs++;
      if (got_s !== exp_s) begin
        errs++;
        $display("FAIL %s strobes c=%0d: got %b expected %b (req,exs,lwe,rab,pcen,br,jmp,flt)",
                 nm, c, got_s, exp_s);
      end
      if (c <= ad) begin
        vecs++;
        if (imem_addr !== pcv) begin
          errs++;
          $display("FAIL %s imem_addr c=%0d: got %h expected %h", nm, c, imem_addr, pcv);
        end
      end
      if (c == l) begin
        vecs++;
        if (link_sel !== instr[11:8]) begin
          errs++;
          $display("FAIL %s link_sel: got %0d expected %0d", nm, link_sel, instr[11:8]);
        end
      end
      if (c == u) begin
        vecs++;
        if ({ir, rtgt_sel, disp, dSrc} !== {instr, instr[3:0], instr[7:0], rd}) begin
          errs++;
          $display("FAIL %s update fields: got ir=%h sel=%0d disp=%h dsrc=%h expected ir=%h sel=%0d disp=%h dsrc=%h",
                   nm, ir, rtgt_sel, disp, dSrc, instr, instr[3:0], instr[7:0], rd);
        end
      end
      #1;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      pc = 16'($urandom);
      imem_ack = 1'b1;
      imem_data = 16'h4E83;
      ex_done = 1'b1;
      rtgt_data = 16'($urandom);
      #1;
      check_all_zero("reset");
      cyc();
    end
    rst = 1'b1;
    run_instr(16'hC07F, 0, 0, 5'b00010, 16'h1234, "reset_bcond");
  endtask

  task automatic test_bcond();
    run_instr(16'hC07F, 0, 0, 5'b00010, 16'h0000, "bcond_taken");
    run_instr(16'hC17F, 0, 0, 5'b00010, 16'h0000, "bcond_not_taken");
    run_instr(16'hCA80, 2, 0, 5'b00000, 16'h0000, "bcond_gt");
  endtask

  task automatic test_jcond();
    run_instr(16'h4EC3, 0, 0, 5'($urandom), 16'h8000, "jcond_always");
    run_instr(16'h4FC3, 1, 0, 5'($urandom), 16'h8000, "jcond_never");
  endtask

  task automatic test_jal();
    run_instr(16'h4E83, 0, 0, 5'($urandom), 16'hFFFF, "jal");
  endtask

  task automatic test_alu();
    run_instr(16'h0531, 0, 3, 5'b11111, 16'h5555, "alu_done3");
    run_instr(16'h0531, 0, 0, 5'b00010, 16'h5555, "alu_done_with_start");
  endtask

  task automatic test_ack_boundary();
    run_instr(16'hCE01, 15, 0, 5'($urandom), 16'h0000, "ack_last_cycle");
  endtask

  task automatic test_timeout();
    logic [1:0] got;
    for (int c = 0; c < 20; c++) begin
      pc = 16'($urandom);
      imem_ack = c >= 17;
      imem_data = 16'hC07F;
      ex_done = 1'($urandom);
      #1;
      got = {imem_req, fault};
      vecs++;
      if (got !== {c < 16, c >= 16}) begin
        errs++;
        $display("FAIL timeout c=%0d: got req,fault=%b expected %b", c, got, {c < 16, c >= 16});
      end
      cyc();
    end
    rst = 1'b0;
    imem_ack = 1'b0;
    #1;
    check_all_zero("fault_reset");
    cyc();
    rst = 1'b1;
    #1;
    vecs++;
    if ({imem_req, fault} !== 2'b10) begin
      errs++;
      $display("FAIL after_fault_reset: got req,fault=%b expected 10", {imem_req, fault});
    end
    run_instr(16'h0123, 3, 1, 5'($urandom), 16'h0F0F, "after_fault");
  endtask

  task automatic test_rst_mid_exec();
    for (int c = 0; c < 4; c++) begin
      pc = 16'($urandom);
      imem_ack = c == 0;
      imem_data = 16'h0531;
      flags = 5'($urandom);
      ex_done = 1'b0;
      #1;
      if (c == 2) begin
        vecs++;
        if (ex_start !== 1'b1) begin
          errs++;
          $display("FAIL mid_exec ex_start: got %b expected 1", ex_start);
        end
      end
      cyc();
    end
    rst = 1'b0;
    ex_done = 1'b1;
    imem_ack = 1'b1;
    #1;
    check_all_zero("mid_exec_reset");
    cyc();
    rst = 1'b1;
    ex_done = 1'b0;
    imem_ack = 1'b0;
    #1;
    vecs++;
    if ({imem_req, pcEn, ex_start, ir} !== {3'b100, 16'h0000}) begin
      errs++;
      $display("FAIL mid_exec_after: got req,pcen,exs=%b ir=%h expected 100 ir=0000",
               {imem_req, pcEn, ex_start}, ir);
    end
    run_instr(16'h4E83, 0, 0, 5'($urandom), 16'h2468, "after_mid_exec");
  endtask

  task automatic test_random();
    logic [15:0] instr;
    for (int i = 0; i < 60; i++) begin
      instr = 16'($urandom);
      case ($urandom_range(0, 3))
        0: instr[15:12] = 4'hC;
        1: {instr[15:12], instr[7:4]} = 8'h4C;
        2: {instr[15:12], instr[7:4]} = 8'h48;
        default: ;
      endcase
      run_instr(instr, $urandom_range(0, 15), $urandom_range(0, 4), 5'($urandom),
                16'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_bcond();
    test_jcond();
    test_jal();
    test_alu();
    test_ack_boundary();
    test_timeout();
    test_rst_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
